// File: rtl/bcd_up_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD up-counter.
package bcd_up_counter_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Prescaler register width: enough bits to hold PRESCALE-1, never less than one.
    function automatic int prescale_width(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_up_counter_if.sv
// Control/data bundle between the counter and whoever drives it.
// The master side supplies enable/clear/load/din; the counter (slave) returns q/tick/wrap.
interface bcd_up_counter_if #(
    parameter int DIGITS = 4
);

    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic [4*DIGITS-1:0]   q;
    logic                  tick;
    logic                  wrap;

    modport master (
        output enable,
        output clear,
        output load,
        output din,
        input  q,
        input  tick,
        input  wrap
    );

    modport slave (
        input  enable,
        input  clear,
        input  load,
        input  din,
        output q,
        output tick,
        output wrap
    );

endinterface

// File: rtl/bcd_digit_up.sv
// One BCD digit of the up-counter: clear/load/increment with a ripple carry out.
module bcd_digit_up
    import bcd_up_counter_pkg::*;
(
    input  logic       clki,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] din_digit,
    input  logic       inc,
    output logic [3:0] q_digit,
    output logic       carry
);

    // The next digit only advances when this one rolls over from 9.
    assign carry = inc && (q_digit == BCD_MAX);

    // Digit register: clear beats load beats increment; non-BCD load values become 0.
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            q_digit <= BCD_ZERO;
        end else if (clear) begin
            q_digit <= BCD_ZERO;
        end else if (load) begin
            q_digit <= (din_digit > BCD_MAX) ? BCD_ZERO : din_digit;
        end else if (inc) begin
            q_digit <= (q_digit == BCD_MAX) ? BCD_ZERO : q_digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_up_counter.sv
// Multi-digit BCD up-counter with prescaler, sync clear/load and tick/wrap pulses.
module bcd_up_counter
    import bcd_up_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50_000_000
) (
    input  logic                 clki,
    input  logic                 reset,
    bcd_up_counter_if.slave      bus
);

    localparam int            PW             = prescale_width(PRESCALE);
    localparam logic [PW-1:0] PRESCALE_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0]         prescaler;
    logic                  step_due;
    logic                  step_blocked;
    logic [DIGITS:0]       carry_chain;
    logic [4*DIGITS-1:0]   count;
    logic                  tick_r;
    logic                  wrap_r;

    // A step is due on the last prescaler phase of an enabled cycle.
    assign step_due     = bus.enable && (prescaler == PRESCALE_LAST);
    // Clear and load discard a due step rather than deferring it.
    assign step_blocked = bus.clear || bus.load;
    assign carry_chain[0] = step_due;

    // Prescaler: restarts on clear/load, advances only while enabled, wraps at PRESCALE-1.
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (step_blocked) begin
            prescaler <= '0;
        end else if (bus.enable) begin
            if (prescaler == PRESCALE_LAST) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    // Ripple the increment through the digits; digit k's carry is digit k+1's inc.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_up u_digit (
            .clki      (clki),
            .reset     (reset),
            .clear     (bus.clear),
            .load      (bus.load),
            .din_digit (bus.din[4*k +: 4]),
            .inc       (carry_chain[k]),
            .q_digit   (count[4*k +: 4]),
            .carry     (carry_chain[k+1])
        );
    end

    // Tick/wrap register: one-cycle pulses aligned with the new count value.
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            tick_r <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            tick_r <= step_due && !step_blocked;
            wrap_r <= carry_chain[DIGITS] && !step_blocked;
        end
    end

    assign bus.q    = count;
    assign bus.tick = tick_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_bcd_up_counter.sv
// Directed testbench for bcd_up_counter with DIGITS=2, PRESCALE=4.
module tb_bcd_up_counter;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;

    logic clki  = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    bcd_up_counter_if #(.DIGITS(DIGITS)) bus ();

    bcd_up_counter #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clki  (clki),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clki = ~clki;

    // Two-digit BCD encoding of a small decimal number, used for expected q.
    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic clr, input logic ld, input logic [7:0] d);
        bus.enable = en;
        bus.clear  = clr;
        bus.load   = ld;
        bus.din    = d;
    endtask

    task automatic nextCycle();
        @(negedge clki);
    endtask

    task automatic checkState(input string tag, input logic [7:0] exp_q, input logic exp_tick, input logic exp_wrap);
        checkOutput({tag, ".q"},    32'(bus.q),    32'(exp_q));
        checkOutput({tag, ".tick"}, 32'(bus.tick), 32'(exp_tick));
        checkOutput({tag, ".wrap"}, 32'(bus.wrap), 32'(exp_wrap));
    endtask

    // One full prescaler period with enable high: three idle cycles, then the step.
    task automatic runPeriod(input string tag, input logic [7:0] prev_q, input logic [7:0] new_q, input logic exp_wrap);
        for (int c = 1; c <= PRESCALE; c++) begin
            nextCycle();
            if (c == PRESCALE) begin
                checkState($sformatf("%s.step", tag), new_q, 1'b1, exp_wrap);
            end else begin
                checkState($sformatf("%s.idle%0d", tag, c), prev_q, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) nextCycle();
        checkState("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int n = 1; n <= 10; n++) begin
            runPeriod($sformatf("count%0d", n), to_bcd(n - 1), to_bcd(n), 1'b0);
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h98);
        nextCycle();
        checkState("load98", 8'h98, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        runPeriod("to99", 8'h98, 8'h99, 1'b0);
        runPeriod("wrap", 8'h99, 8'h00, 1'b1);
        nextCycle();
        checkState("after_wrap", 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'hA7);
        nextCycle();
        checkState("loadA7", 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        runPeriod("to08", 8'h07, 8'h08, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h42);
        nextCycle();
        checkState("load42", 8'h42, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int c = 1; c < PRESCALE; c++) begin
            nextCycle();
            checkState($sformatf("pre_clear%0d", c), 8'h42, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        nextCycle();
        checkState("clear_on_step", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        runPeriod("after_clear", 8'h00, 8'h01, 1'b0);

        for (int c = 1; c <= 2; c++) begin
            nextCycle();
            checkState($sformatf("pre_hold%0d", c), 8'h01, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            checkState($sformatf("hold%0d", c), 8'h01, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        nextCycle();
        checkState("resume1", 8'h01, 1'b0, 1'b0);
        nextCycle();
        checkState("resume2", 8'h02, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'h57);
        nextCycle();
        checkState("load57", 8'h57, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1 checkState("async_reset", 8'h00, 1'b0, 1'b0);
        #1 reset = 1'b0;
        runPeriod("restart", 8'h00, 8'h01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
